product_block_reducer: RTL and testbench

- Downstream consumer of the multiplier/product buffer read port.
- On a start pulse, requests a block read (EN_blockRead), collects the streamed product words (VALID_memVal/memVal_data) and reduces them to a sum, a maximum and a word count.
- Presents the result on a valid/ready output handshake.
- Detects a non-responding producer (request timeout) and a truncated stream (inter-word gap).

---
 rtl/product_block_reducer.sv | 82 ++++++++
 tb/tb_product_block_reducer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/product_block_reducer.sv
// product_block_reducer: requests a product block, reduces it to sum/max/count, reports timeout or truncation.
module product_block_reducer #(
  parameter int LOGDEPTH = 6,
  parameter int WIDTH = 32,
  parameter int TIMEOUT = 255,
  parameter int GAP_MAX = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      EN_blockRead,
  input  logic                      VALID_memVal,
  input  logic [WIDTH-1:0]          memVal_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [WIDTH+LOGDEPTH-1:0] res_sum,
  output logic [WIDTH-1:0]          res_max,
  output logic [LOGDEPTH:0]         res_count,
  output logic                      res_timeout,
  output logic                      res_short,
  output logic                      busy
);
  localparam int DEPTH = 1 << LOGDEPTH;
  localparam int CW = LOGDEPTH + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_MAX + 1);
  typedef enum logic [1:0] {IDLE, REQ, COLLECT, HOLD} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap;
  logic accept, last_word, timer_end, gap_end;
  assign accept = VALID_memVal && (state == REQ || state == COLLECT);
  assign last_word = res_count == CW'(DEPTH - 1);
  assign timer_end = timer == TW'(TIMEOUT - 1);
  assign gap_end = gap == GW'(GAP_MAX - 1);
  assign EN_blockRead = state == REQ;
  assign res_valid = state == HOLD;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? REQ : IDLE;
      REQ:     state_n = VALID_memVal ? (last_word ? HOLD : COLLECT) : (timer_end ? HOLD : REQ);
      COLLECT: state_n = (VALID_memVal ? last_word : gap_end) ? HOLD : COLLECT;
      HOLD:    state_n = res_ready ? IDLE : HOLD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      res_sum <= '0;
      res_max <= '0;
      res_count <= '0;
      res_timeout <= 1'b0;
      res_short <= 1'b0;
      timer <= '0;
      gap <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        res_sum <= '0;
        res_max <= '0;
        res_count <= '0;
        res_timeout <= 1'b0;
        res_short <= 1'b0;
        timer <= '0;
        gap <= '0;
      end else if (accept) begin
        res_sum <= res_sum + {{LOGDEPTH{1'b0}}, memVal_data};
        res_max <= memVal_data > res_max ? memVal_data : res_max;
        res_count <= res_count + 1'b1;
        gap <= '0;
      end else if (state == REQ) begin
        timer <= timer + 1'b1;
        res_timeout <= timer_end;
      end else if (state == COLLECT) begin
        gap <= gap + 1'b1;
        res_short <= gap_end;
      end
    end
  end
endmodule

// File: tb/tb_product_block_reducer.sv
// tb_product_block_reducer: directed blocks with a result scoreboard checked at each handshake.
module tb_product_block_reducer;
  logic clk = 0, rst = 1, start = 0, VALID_memVal = 0, res_ready = 0;
  logic [31:0] memVal_data = 0;
  logic EN_blockRead, res_valid, res_timeout, res_short, busy;
  logic [37:0] res_sum;
  logic [31:0] res_max;
  logic [6:0] res_count;
  int n_checks = 0, n_fail = 0, en_cycles = 0, waited;
  typedef struct {
    logic [63:0] sum;
    logic [63:0] max;
    int count;
    bit to;
    bit sh;
  } exp_t;
  exp_t q[$];

  product_block_reducer dut (
    .clk(clk), .rst(rst), .start(start), .EN_blockRead(EN_blockRead),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data), .res_valid(res_valid),
    .res_ready(res_ready), .res_sum(res_sum), .res_max(res_max), .res_count(res_count),
    .res_timeout(res_timeout), .res_short(res_short), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (EN_blockRead) en_cycles++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (res_valid && res_ready) begin
      if (q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = q.pop_front();
        chk("res_sum", 64'(res_sum), e.sum);
        chk("res_max", 64'(res_max), e.max);
        chk("res_count", 64'(res_count), 64'(e.count));
        chk("res_timeout", 64'(res_timeout), 64'(e.to));
        chk("res_short", 64'(res_short), 64'(e.sh));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1;
    tick;
    start = 0;
  endtask

  task automatic send(input logic [31:0] w);
    VALID_memVal = 1;
    memVal_data = w;
    tick;
    VALID_memVal = 0;
    memVal_data = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick;
  endtask

  task automatic wait_result(output int w);
    w = 0;
    while (!res_valid && w < 400) begin
      tick;
      w++;
    end
    chk("res_valid_seen", 64'(res_valid), 1);
  endtask

  task automatic ack;
    res_ready = 1;
    tick;
    res_ready = 0;
    chk("idle_after_ack", {62'd0, res_valid, busy}, 0);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {res_sum, res_max, res_count, EN_blockRead, res_valid, res_timeout, res_short, busy}, 0);
  endtask

  initial begin
    int bad;
    tick;
    tick;
    chk_zero("reset_outputs");
    chk("reset_sum", 64'(res_sum), 0);
    rst = 0;
    tick;
    chk("idle_busy", 64'(busy), 0);

    // full block answered after 3 idle request cycles
    q.push_back('{64'd2080, 64'd64, 64, 1'b0, 1'b0});
    en_cycles = 0;
    do_start;
    chk("busy_req", {62'd0, busy, EN_blockRead}, 3);
    idle(3);
    for (int i = 1; i <= 64; i++) send(32'(i));
    chk("en_cycles_full", 64'(en_cycles), 4);
    wait_result(waited);
    chk("full_latency", 64'(waited), 0);
    ack;

    // 63 max-value words then the producer stops
    q.push_back('{64'd270582939585, 64'hFFFF_FFFF, 63, 1'b0, 1'b1});
    do_start;
    for (int i = 0; i < 63; i++) send(32'hFFFF_FFFF);
    wait_result(waited);
    chk("gap_latency", 64'(waited), 3);
    ack;

    // no producer response
    q.push_back('{64'd0, 64'd0, 0, 1'b1, 1'b0});
    en_cycles = 0;
    do_start;
    wait_result(waited);
    chk("timeout_latency", 64'(waited), 255);
    chk("en_cycles_timeout", 64'(en_cycles), 255);
    ack;

    // backpressure, with a start during HOLD and one on the handshake edge
    q.push_back('{64'd11, 64'd6, 2, 1'b0, 1'b1});
    do_start;
    send(5);
    send(6);
    wait_result(waited);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      if (!(res_valid && busy && res_sum == 11 && res_max == 6 && res_count == 2 && res_short && !res_timeout))
        bad++;
      tick;
    end
    start = 1;
    ack;
    start = 0;
    idle(2);
    chk("hold_stable_cycles_bad", 64'(bad), 0);
    chk("start_in_hold_ignored", {62'd0, busy, EN_blockRead}, 0);

    // 2-cycle gap does not end the block; valids after the last word are ignored
    q.push_back('{64'd82, 64'd9, 64, 1'b0, 1'b0});
    do_start;
    send(5);
    send(9);
    idle(2);
    send(7);
    for (int i = 0; i < 61; i++) send(1);
    wait_result(waited);
    chk("full_gap_latency", 64'(waited), 0);
    send(99);
    ack;

    // reset in COLLECT leaves no residue
    do_start;
    for (int i = 0; i < 20; i++) send(3);
    rst = 1;
    tick;
    rst = 0;
    chk_zero("mid_reset_outputs");
    q.push_back('{64'd128, 64'd2, 64, 1'b0, 1'b0});
    do_start;
    for (int i = 0; i < 64; i++) send(2);
    wait_result(waited);
    ack;

    idle(2);
    chk("scoreboard_drained", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
